fetch_stage: RTL and testbench

- IF stage of the 5-stage RV32I lab pipeline. It holds the PC, drives instruction-memory address, and predicts next PC with a direct-mapped BHT (2-bit counters) plus BTB.
- Feeds the IF/ID pipeline register: instruction word, fetch PC, predicted-taken flag, flush (bubble) flag.
- Takes mispredict redirects and branch-resolution updates from EX, and stall from the hazard unit.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_stage_branch_predictor.sv | 81 ++++++++
 rtl/fetch_stage.sv | 82 ++++++++
 tb/tb_fetch_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the IF stage and its branch predictor.
package fetch_pkg;

  localparam int PC_W  = 12;
  localparam int IDX_W = 4;
  localparam logic [PC_W-1:0] RESET_PC = 12'h000;

  // Byte distance between sequential instruction fetches.
  localparam int PC_INC = 4;

  // Two-bit saturating branch counter states.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

endpackage

// File: rtl/fetch_stage_branch_predictor.sv
// Direct-mapped BHT (2-bit counters) plus BTB. Lookup is combinational on the
// fetch PC; updates from EX are written on the clock edge, so a lookup in the
// same cycle as an update to the same index still sees the old entry.
module branch_predictor
  import fetch_pkg::*;
#(
  parameter int PC_W  = fetch_pkg::PC_W,
  parameter int IDX_W = fetch_pkg::IDX_W
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic [PC_W-1:0] lk_pc,
  output logic            lk_taken,
  output logic [PC_W-1:0] lk_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = PC_W - IDX_W - 2;

  logic [1:0]       ctr_tbl [ENTRIES];
  logic             btb_vld [ENTRIES];
  logic [TAG_W-1:0] btb_tag [ENTRIES];
  logic [PC_W-1:0]  btb_tgt [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [TAG_W-1:0] upd_tag;
  logic             lk_hit;
  logic             unused_pc_lsbs;

  function automatic logic [1:0] ctr_sat_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_sat_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[PC_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[PC_W-1:IDX_W+2];

  // Byte-offset bits never select an entry: instructions are word-aligned.
  assign unused_pc_lsbs = ^{lk_pc[1:0], upd_pc[1:0]};

  assign lk_hit    = btb_vld[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  assign lk_taken  = lk_hit && ctr_tbl[lk_idx][1];
  assign lk_target = btb_tgt[lk_idx];

  // Counters and valid bits: reset to weakly-not-taken / empty, then train on EX outcomes.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_tbl[i] <= WNT;
        btb_vld[i] <= 1'b0;
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        ctr_tbl[upd_idx] <= ctr_sat_inc(ctr_tbl[upd_idx]);
        btb_vld[upd_idx] <= 1'b1;
      end else begin
        ctr_tbl[upd_idx] <= ctr_sat_dec(ctr_tbl[upd_idx]);
      end
    end
  end

  // Tag/target payload is only meaningful under btb_vld, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (upd_valid && upd_taken) begin
      btb_tag[upd_idx] <= upd_tag;
      btb_tgt[upd_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection (redirect > halt > stall > predict)
// and the bubble flag presented to the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              PC_W     = fetch_pkg::PC_W,
  parameter int              IDX_W    = fetch_pkg::IDX_W,
  parameter logic [PC_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            stall_i,
  input  logic            halt_i,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic [31:0]     imem_data_i,
  output logic [31:0]     inst_o,
  output logic [PC_W-1:0] pc_o,
  output logic            bpr_o,
  output logic            flush_o,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            upd_valid_i,
  input  logic [PC_W-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [PC_W-1:0] upd_target_i
);

  logic [PC_W-1:0] pc_p0;
  logic            started_p0;
  logic            halted_p0;
  logic            bp_taken;
  logic [PC_W-1:0] bp_target;
  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] pred_next;

  branch_predictor #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W)
  ) u_bp (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .lk_pc      (pc_p0),
    .lk_taken   (bp_taken),
    .lk_target  (bp_target),
    .upd_valid  (upd_valid_i),
    .upd_pc     (upd_pc_i),
    .upd_taken  (upd_taken_i),
    .upd_target (upd_target_i)
  );

  // Sequential fetch wraps naturally modulo 2**PC_W.
  assign pc_seq    = pc_p0 + PC_W'(PC_INC);
  assign pred_next = bp_taken ? bp_target : pc_seq;

  assign imem_addr_o = pc_p0;
  assign pc_o        = pc_p0;
  assign inst_o      = imem_data_i;
  assign bpr_o       = bp_taken;

  // Redirect and halt squash the slot now in IF in the same cycle they are seen.
  assign flush_o = ~started_p0 | redirect_i | halted_p0 | halt_i;

  // PC and control flags: a redirect is the only way out of the halted state.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      pc_p0      <= RESET_PC;
      started_p0 <= 1'b0;
      halted_p0  <= 1'b0;
    end else begin
      started_p0 <= 1'b1;
      if (redirect_i) begin
        pc_p0     <= redirect_pc_i;
        halted_p0 <= 1'b0;
      end else if (halted_p0 || halt_i) begin
        halted_p0 <= 1'b1;
      end else if (!stall_i) begin
        pc_p0 <= pred_next;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a reference model pushes the expected IF outputs for
// each cycle into a scoreboard queue; the DUT outputs are popped and compared.
module tb_fetch_stage;

  localparam int PW = 12;
  localparam int N  = 16;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          stall_i = 1'b0;
  logic          halt_i = 1'b0;
  logic          redirect_i = 1'b0;
  logic [PW-1:0] redirect_pc_i = '0;
  logic          upd_valid_i = 1'b0;
  logic [PW-1:0] upd_pc_i = '0;
  logic          upd_taken_i = 1'b0;
  logic [PW-1:0] upd_target_i = '0;
  logic [PW-1:0] imem_addr_o;
  logic [31:0]   imem_data_i;
  logic [31:0]   inst_o;
  logic [PW-1:0] pc_o;
  logic          bpr_o;
  logic          flush_o;

  fetch_stage dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .stall_i       (stall_i),
    .halt_i        (halt_i),
    .imem_addr_o   (imem_addr_o),
    .imem_data_i   (imem_data_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .bpr_o         (bpr_o),
    .flush_o       (flush_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .upd_target_i  (upd_target_i)
  );

  always #5 CLK = ~CLK;

  // Instruction memory: word content encodes its own address.
  assign imem_data_i = {20'hA5C3B, imem_addr_o};

  typedef struct packed {
    logic [PW-1:0] pc;
    logic          bpr;
    logic          flush;
    logic [31:0]   inst;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state.
  logic [PW-1:0] m_pc;
  logic          m_started;
  logic          m_halted;
  logic [1:0]    m_ctr [N];
  logic          m_vld [N];
  logic [5:0]    m_tag [N];
  logic [PW-1:0] m_tgt [N];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 12'h000;
    m_started = 1'b0;
    m_halted  = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_ctr[i] = 2'b01;
      m_vld[i] = 1'b0;
    end
  endtask

  task automatic clr();
    stall_i = 0; halt_i = 0; redirect_i = 0; redirect_pc_i = '0;
    upd_valid_i = 0; upd_taken_i = 0; upd_pc_i = '0; upd_target_i = '0;
  endtask

  task automatic redir(input logic [PW-1:0] pc);
    redirect_i = 1; redirect_pc_i = pc;
  endtask

  task automatic upd(input logic [PW-1:0] pc, input logic tk, input logic [PW-1:0] tgt);
    upd_valid_i = 1; upd_pc_i = pc; upd_taken_i = tk; upd_target_i = tgt;
  endtask

  // Directly stated expectations for the current cycle (inputs already applied).
  task automatic tp(input string tag, input logic [PW-1:0] pc, input logic bpr, input logic fl);
    #1;
    chk({tag, ".pc"}, pc_o, pc);
    chk({tag, ".bpr"}, bpr_o, bpr);
    chk({tag, ".flush"}, flush_o, fl);
  endtask

  // One clock cycle: push model expectation, compare DUT, advance model at the edge.
  task automatic step(input string tag);
    exp_t          e;
    exp_t          o;
    logic [PW-1:0] nxt;
    int            i;
    int            u;
    i       = int'(m_pc[5:2]);
    e.pc    = m_pc;
    e.bpr   = m_vld[i] && (m_tag[i] == m_pc[11:6]) && m_ctr[i][1];
    e.flush = !m_started || redirect_i || m_halted || halt_i;
    e.inst  = {20'hA5C3B, m_pc};
    sb_q.push_back(e);
    #1;
    o = sb_q.pop_front();
    chk({tag, ".pc"}, pc_o, o.pc);
    chk({tag, ".addr"}, imem_addr_o, o.pc);
    chk({tag, ".bpr"}, bpr_o, o.bpr);
    chk({tag, ".flush"}, flush_o, o.flush);
    chk({tag, ".inst"}, inst_o, o.inst);
    nxt = e.bpr ? m_tgt[i] : m_pc + 12'd4;
    @(posedge CLK);
    m_started = 1'b1;
    if (redirect_i) begin
      m_pc = redirect_pc_i; m_halted = 1'b0;
    end else if (m_halted || halt_i) begin
      m_halted = 1'b1;
    end else if (!stall_i) begin
      m_pc = nxt;
    end
    if (upd_valid_i) begin
      u = int'(upd_pc_i[5:2]);
      if (upd_taken_i) begin
        m_ctr[u] = (m_ctr[u] == 2'b11) ? 2'b11 : m_ctr[u] + 2'd1;
        m_vld[u] = 1'b1;
        m_tag[u] = upd_pc_i[11:6];
        m_tgt[u] = upd_target_i;
      end else begin
        m_ctr[u] = (m_ctr[u] == 2'b00) ? 2'b00 : m_ctr[u] - 2'd1;
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      m_tag[i] = '0;
      m_tgt[i] = '0;
    end
    model_reset();
    clr();
    RSTn = 0;
    @(posedge CLK);
    @(negedge CLK);
    tp("rst", 12'h000, 1'b0, 1'b1);
    RSTn = 1;

    // Free run after reset
    step("run0");
    upd(12'h010, 1, 12'h040); step("run1");
    step("run2");
    clr(); step("run3");
    // Trained branch at 010 predicted taken to 040
    tp("hit", 12'h010, 1'b1, 1'b0); step("hit");
    tp("tgt", 12'h040, 1'b0, 1'b0);
    redir(12'h014); step("misp");
    clr(); tp("misp_new", 12'h014, 1'b0, 1'b0); step("seq");
    redir(12'h008); step("to008");
    // Stall two cycles at 008
    clr(); stall_i = 1; tp("stall0", 12'h008, 1'b0, 1'b0); step("stall0");
    tp("stall1", 12'h008, 1'b0, 1'b0); step("stall1");
    clr(); tp("rel", 12'h008, 1'b0, 1'b0); step("rel");
    tp("rel_next", 12'h00C, 1'b0, 1'b0);
    stall_i = 1; redir(12'h100); step("stall_redir");
    // Not-taken saturation at 010
    clr(); tp("redir100", 12'h100, 1'b0, 1'b0);
    upd(12'h010, 0, 12'h000); step("nt0");
    step("nt1");
    step("nt2");
    redir(12'h010); step("nt3");
    clr(); tp("sat", 12'h010, 1'b0, 1'b0);
    upd(12'h410, 1, 12'h080); step("alias0");
    step("alias1");
    clr(); redir(12'h010); step("alias2");
    clr(); tp("alias_old", 12'h010, 1'b0, 1'b0);
    redir(12'h410); step("alias_old");
    clr(); tp("alias_new", 12'h410, 1'b1, 1'b0); step("alias_new");
    tp("alias_tgt", 12'h080, 1'b0, 1'b0);
    redir(12'hFFC); step("toffc");
    // Wrap
    clr(); tp("ffc", 12'hFFC, 1'b0, 1'b0); step("ffc");
    tp("wrap", 12'h000, 1'b0, 1'b0);
    redir(12'h020); step("to020");
    // Halt pulse, update during halt, redirect resumes
    clr(); tp("h020", 12'h020, 1'b0, 1'b0);
    halt_i = 1; step("halt0");
    clr(); upd(12'h030, 1, 12'h100); tp("halt1", 12'h020, 1'b0, 1'b1); step("halt1");
    clr(); tp("halt2", 12'h020, 1'b0, 1'b1);
    redir(12'h030); step("halt2");
    clr(); tp("resume", 12'h030, 1'b1, 1'b0); step("resume");
    tp("resume_tgt", 12'h100, 1'b0, 1'b0); step("resume_tgt");

    // Mid-operation reset discards predictor state
    RSTn = 0;
    @(posedge CLK);
    @(negedge CLK);
    model_reset();
    tp("rst2", 12'h000, 1'b0, 1'b1);
    RSTn = 1;
    redir(12'h030); step("r2_0");
    clr(); upd(12'h030, 1, 12'h200); tp("r2_same", 12'h030, 1'b0, 1'b0); step("r2_same");
    tp("r2_seq", 12'h034, 1'b0, 1'b0); step("r2_seq");
    clr(); redir(12'h030); step("r2_redir");
    clr(); tp("r2_hit", 12'h030, 1'b1, 1'b0); step("r2_hit");
    tp("r2_tgt", 12'h200, 1'b0, 1'b0); step("r2_tgt");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
